// File: rtl/jtag_tap_sync.sv
// JtagTapSync: IEEE 1149.1 TAP controller oversampled by the system clock.
// The raw JTAG pins are synchronized into the clock domain and every TCK
// edge is recovered by edge detection, so all state lives on clock.
// Instructions: IDCODE (5'h01), USER (5'h11), everything else BYPASS.
// Optional feature: define JTAG_TAP_TRST_EN to honour jtag_TRSTn as an
// additional reset source; without it jtag_TRSTn is ignored.
module jtag_tap_sync #(
  parameter logic [31:0] IDCODE    = 32'h1000_0A6F,
  parameter int          USER_DR_W = 41   // legal range 8..64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 jtag_TCK,
  input  logic                 jtag_TMS,
  input  logic                 jtag_TDI,
  input  logic                 jtag_TRSTn,
  output logic                 jtag_TDO_data,
  output logic                 jtag_TDO_driven,
  input  logic [USER_DR_W-1:0] user_capture_data,
  output logic                 user_cap_pulse,
  output logic                 user_upd_valid,
  output logic [USER_DR_W-1:0] user_upd_data
);

  // TAP controller state encoding
  localparam logic [3:0] TLR        = 4'h0;
  localparam logic [3:0] RTI        = 4'h1;
  localparam logic [3:0] SEL_DR     = 4'h2;
  localparam logic [3:0] CAPTURE_DR = 4'h3;
  localparam logic [3:0] SHIFT_DR   = 4'h4;
  localparam logic [3:0] EXIT1_DR   = 4'h5;
  localparam logic [3:0] PAUSE_DR   = 4'h6;
  localparam logic [3:0] EXIT2_DR   = 4'h7;
  localparam logic [3:0] UPDATE_DR  = 4'h8;
  localparam logic [3:0] SEL_IR     = 4'h9;
  localparam logic [3:0] CAPTURE_IR = 4'hA;
  localparam logic [3:0] SHIFT_IR   = 4'hB;
  localparam logic [3:0] EXIT1_IR   = 4'hC;
  localparam logic [3:0] PAUSE_IR   = 4'hD;
  localparam logic [3:0] EXIT2_IR   = 4'hE;
  localparam logic [3:0] UPDATE_IR  = 4'hF;

  // Instruction opcodes
  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_USER   = 5'h11;

  // Synchronizer flops
  logic r_tckS1;
  logic r_tckS2;
  logic r_tckS3;
  logic r_tmsS1;
  logic r_tmsS2;
  logic r_tdiS1;
  logic r_tdiS2;

  // TAP state and registers
  logic [3:0]           r_state;
  logic [4:0]           r_ir;
  logic [4:0]           r_irShift;
  logic [31:0]          r_idShift;
  logic [USER_DR_W-1:0] r_userShift;
  logic                 r_bypass;

  // Decoded control
  logic       w_forceRst;
  logic       w_tckRise;
  logic       w_tckFall;
  logic [3:0] w_stateNext;
  logic       w_enterTlr;
  logic       w_enterCapIr;
  logic       w_enterUpdIr;
  logic       w_enterCapDr;
  logic       w_enterUpdDr;
  logic       w_selIdcode;
  logic       w_selUser;
  logic       w_selBypass;
  logic       w_drLsb;

  // Pin synchronizers; TCK gets a third stage so both edges can be seen
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tckS1 <= 1'b0;
      r_tckS2 <= 1'b0;
      r_tckS3 <= 1'b0;
      r_tmsS1 <= 1'b0;
      r_tmsS2 <= 1'b0;
      r_tdiS1 <= 1'b0;
      r_tdiS2 <= 1'b0;
    end else begin
      r_tckS1 <= jtag_TCK;
      r_tckS2 <= r_tckS1;
      r_tckS3 <= r_tckS2;
      r_tmsS1 <= jtag_TMS;
      r_tmsS2 <= r_tmsS1;
      r_tdiS1 <= jtag_TDI;
      r_tdiS2 <= r_tdiS1;
    end
  end

`ifdef JTAG_TAP_TRST_EN
  logic r_trstS1;
  logic r_trstS2;

  // TRSTn synchronizer; a low level acts as a TAP-wide reset each clock
  always_ff @(posedge clock) begin
    if (reset) begin
      r_trstS1 <= 1'b0;
      r_trstS2 <= 1'b0;
    end else begin
      r_trstS1 <= jtag_TRSTn;
      r_trstS2 <= r_trstS1;
    end
  end

  assign w_forceRst = reset | ~r_trstS2;
`else
  logic w_unusedTrst;
  assign w_unusedTrst = jtag_TRSTn;
  assign w_forceRst   = reset;
`endif

  assign w_tckRise = r_tckS2 & ~r_tckS3;
  assign w_tckFall = ~r_tckS2 & r_tckS3;

  // Standard 16-state TAP next-state decode from synchronized TMS
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      TLR:        w_stateNext = r_tmsS2 ? TLR       : RTI;
      RTI:        w_stateNext = r_tmsS2 ? SEL_DR    : RTI;
      SEL_DR:     w_stateNext = r_tmsS2 ? SEL_IR    : CAPTURE_DR;
      CAPTURE_DR: w_stateNext = r_tmsS2 ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:   w_stateNext = r_tmsS2 ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:   w_stateNext = r_tmsS2 ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:   w_stateNext = r_tmsS2 ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:   w_stateNext = r_tmsS2 ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:  w_stateNext = r_tmsS2 ? SEL_DR    : RTI;
      SEL_IR:     w_stateNext = r_tmsS2 ? TLR       : CAPTURE_IR;
      CAPTURE_IR: w_stateNext = r_tmsS2 ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:   w_stateNext = r_tmsS2 ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:   w_stateNext = r_tmsS2 ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:   w_stateNext = r_tmsS2 ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:   w_stateNext = r_tmsS2 ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:  w_stateNext = r_tmsS2 ? SEL_DR    : RTI;
      default:    w_stateNext = TLR;
    endcase
  end

  // Capture and update actions fire on the TCK rise that enters the state,
  // so the user pulses line up with the register load they announce
  assign w_enterTlr   = w_tckRise & (w_stateNext == TLR);
  assign w_enterCapIr = w_tckRise & (w_stateNext == CAPTURE_IR);
  assign w_enterUpdIr = w_tckRise & (w_stateNext == UPDATE_IR);
  assign w_enterCapDr = w_tckRise & (w_stateNext == CAPTURE_DR);
  assign w_enterUpdDr = w_tckRise & (w_stateNext == UPDATE_DR);

  assign w_selIdcode = (r_ir == IR_IDCODE);
  assign w_selUser   = (r_ir == IR_USER);
  assign w_selBypass = ~w_selIdcode & ~w_selUser;

  assign w_drLsb = w_selIdcode ? r_idShift[0] :
                   w_selUser   ? r_userShift[0] : r_bypass;

  // TAP state register, advanced once per detected TCK rise
  always_ff @(posedge clock) begin
    if (w_forceRst) begin
      r_state <= TLR;
    end else if (w_tckRise) begin
      r_state <= w_stateNext;
    end
  end

  // Instruction register: IDCODE whenever in or entering Test-Logic-Reset
  always_ff @(posedge clock) begin
    if (w_forceRst) begin
      r_ir <= IR_IDCODE;
    end else if ((r_state == TLR) || w_enterTlr) begin
      r_ir <= IR_IDCODE;
    end else if (w_enterUpdIr) begin
      r_ir <= r_irShift;
    end
  end

  // IR shift register: capture fixed pattern, shift right with TDI at MSB
  always_ff @(posedge clock) begin
    if (w_forceRst) begin
      r_irShift <= 5'b0;
    end else if (w_enterCapIr) begin
      r_irShift <= 5'b00001;
    end else if (w_tckRise && (r_state == SHIFT_IR)) begin
      r_irShift <= {r_tdiS2, r_irShift[4:1]};
    end
  end

  // IDCODE data register
  always_ff @(posedge clock) begin
    if (w_forceRst) begin
      r_idShift <= 32'b0;
    end else if (w_enterCapDr && w_selIdcode) begin
      r_idShift <= IDCODE;
    end else if (w_tckRise && (r_state == SHIFT_DR) && w_selIdcode) begin
      r_idShift <= {r_tdiS2, r_idShift[31:1]};
    end
  end

  // USER data register, loaded from the fabric-side capture bus
  always_ff @(posedge clock) begin
    if (w_forceRst) begin
      r_userShift <= '0;
    end else if (w_enterCapDr && w_selUser) begin
      r_userShift <= user_capture_data;
    end else if (w_tckRise && (r_state == SHIFT_DR) && w_selUser) begin
      r_userShift <= {r_tdiS2, r_userShift[USER_DR_W-1:1]};
    end
  end

  // Single-bit BYPASS register, captures zero
  always_ff @(posedge clock) begin
    if (w_forceRst) begin
      r_bypass <= 1'b0;
    end else if (w_enterCapDr && w_selBypass) begin
      r_bypass <= 1'b0;
    end else if (w_tckRise && (r_state == SHIFT_DR) && w_selBypass) begin
      r_bypass <= r_tdiS2;
    end
  end

  // TDO is retimed on the TCK fall and only driven in the two shift states
  always_ff @(posedge clock) begin
    if (w_forceRst) begin
      jtag_TDO_data   <= 1'b0;
      jtag_TDO_driven <= 1'b0;
    end else if (w_tckFall) begin
      case (r_state)
        SHIFT_IR: begin
          jtag_TDO_data   <= r_irShift[0];
          jtag_TDO_driven <= 1'b1;
        end
        SHIFT_DR: begin
          jtag_TDO_data   <= w_drLsb;
          jtag_TDO_driven <= 1'b1;
        end
        default: begin
          jtag_TDO_data   <= 1'b0;
          jtag_TDO_driven <= 1'b0;
        end
      endcase
    end
  end

  // One-clock capture/update strobes for the USER register plus held data
  always_ff @(posedge clock) begin
    if (w_forceRst) begin
      user_cap_pulse <= 1'b0;
      user_upd_valid <= 1'b0;
      user_upd_data  <= '0;
    end else begin
      user_cap_pulse <= w_enterCapDr & w_selUser;
      user_upd_valid <= w_enterUpdDr & w_selUser;
      if (w_enterUpdDr && w_selUser) begin
        user_upd_data <= r_userShift;
      end
    end
  end

endmodule

// File: doc/jtag_tap_sync.md
JTAG_TAP_SYNC -- requirements
Module: jtag_tap_sync

Interface
- REQ-001 SHALL have parameter IDCODE, default 32'h1000_0A6F, value returned by the IDCODE DR (bit 0 SHALL be 1).
- REQ-002 SHALL have parameter USER_DR_W, default 41, width of the USER DR, legal range 8..64.
- REQ-003 SHALL have port clock, input, 1, system clock; all state on its rising edge.
- REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
- REQ-005 SHALL have ports jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, each input, 1, raw JTAG pins asynchronous to clock.
- REQ-006 SHALL have port jtag_TDO_data, output, 1, serial data out.
- REQ-007 SHALL have port jtag_TDO_driven, output, 1, high while TDO is valid (Shift-IR/Shift-DR).
- REQ-008 SHALL have port user_capture_data, input, USER_DR_W, value loaded into the USER DR at Capture-DR.
- REQ-009 SHALL have port user_cap_pulse, output, 1, one-clock pulse when the USER DR is captured.
- REQ-010 SHALL have port user_upd_valid, output, 1, one-clock pulse at Update-DR with IR=USER.
- REQ-011 SHALL have port user_upd_data, output, USER_DR_W, USER shift register contents, valid with user_upd_valid.

Function
- REQ-012 SHALL pass TCK, TMS, TDI and TRSTn through 2-flop synchronizers; TCK SHALL feed a third flop for edge detection (rise = s2 & ~s3, fall = ~s2 & s3).
- REQ-013 SHALL require TCK high and low phases of at least 3 clocks; faster TCK behaviour is undefined.
- REQ-014 SHALL advance the standard 16-state IEEE 1149.1 TAP FSM using synchronized TMS on each detected TCK rise, updating on the 3rd clock edge after the raw TCK rise.
- REQ-015 SHALL hold a 5-bit IR; Capture-IR loads 5'b00001 into the IR shift register; Shift-IR shifts right, TDI into MSB; Update-IR copies shift register to IR.
- REQ-016 SHALL decode IR 5'h01=IDCODE, 5'h11=USER, 5'h1F and all other values=BYPASS.
- REQ-017 SHALL at Capture-DR load IDCODE (32 bits), user_capture_data (USER_DR_W bits) or 1'b0 (BYPASS) into the selected DR shift register.
- REQ-018 SHALL in Shift-DR shift the selected DR right, TDI into MSB, LSB presented to TDO.
- REQ-019 SHALL on each TCK fall update jtag_TDO_data to the selected shift register LSB and jtag_TDO_driven to 1 if the state is Shift-IR/Shift-DR, else TDO_driven 0 and TDO_data 0.
- REQ-020 SHALL pulse user_cap_pulse one clock in the clock where the FSM enters Capture-DR with IR=USER.
- REQ-021 SHALL pulse user_upd_valid one clock when the FSM enters Update-DR with IR=USER; user_upd_data SHALL hold its value until the next update.
- REQ-022 SHALL set IR to IDCODE whenever the FSM is in Test-Logic-Reset.
- REQ-023 SHALL reach Test-Logic-Reset after 5 consecutive TCK rises with TMS=1 from any state.

Reset
- REQ-024 SHALL on reset force FSM to Test-Logic-Reset, IR=5'h01, all shift registers 0, synchronizer flops 0, jtag_TDO_data=0, jtag_TDO_driven=0, user_cap_pulse=0, user_upd_valid=0, user_upd_data=0.
- REQ-025 SHALL abandon any in-progress shift on reset without issuing user_upd_valid.

Configuration
- REQ-026 SHALL honour macro JTAG_TAP_TRST_EN: when defined, synchronized jtag_TRSTn=0 forces the REQ-024 state (except synchronizers) each clock; when undefined, jtag_TRSTn SHALL be ignored and its synchronizer omitted.

Verification
- REQ-027 SHALL cover: reset, 5x TMS=1, read 32-bit DR -> TDO yields 32'h1000_0A6F LSB first, TDO_driven high for exactly 32 falls.
- REQ-028 SHALL cover: shift IR with TDI 5'h1F, Capture-IR observed -> TDO yields 5'b00001; then Shift-DR TDI 1,0,1,1 -> TDO 0,1,0,1,1 (one-TCK delay).
- REQ-029 SHALL cover: IR=5'h11, user_capture_data=41'h1_2345_6789A, shift in 41'h0_ABCD_EF012 -> TDO yields 41'h1_2345_6789A, one user_cap_pulse, one user_upd_valid with user_upd_data=41'h0_ABCD_EF012.
- REQ-030 SHALL cover: reset asserted mid Shift-DR (IR=USER) -> next clock TLR state, IR=5'h01, TDO_driven=0, no user_upd_valid.
- REQ-031 SHALL cover: TCK rise with TMS=1 from Run-Test/Idle -> state change on exactly the 3rd clock edge after raw TCK rise.
- REQ-032 SHALL cover (JTAG_TAP_TRST_EN defined): TRSTn low 4 clocks during Shift-IR with no TCK edges -> TLR and IR=5'h01 within 3 clocks; undefined: no state change.
